// File: rtl/bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter using shift-and-add-3.
// Converts one bit per clock and delivers a result 8 cycles after an accepted START.
module bin2bcd8 (
    input  logic        CLOCK,
    input  logic        RESET_B,
    input  logic [7:0]  BIN,
    input  logic        START,
    output logic [11:0] BCD,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [11:0] bcd_q,   bcd_d;

    logic [19:0] adj;
    logic [19:0] shifted;

    // Binary part passes through; each BCD nibble is corrected from its pre-adjust value
    assign adj[7:0] = shift_q[7:0];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = shift_q[8 + 4*gi +: 4];
            assign adj[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    assign shifted = {adj[18:0], 1'b0};

    always_ff @(posedge CLOCK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q <= IDLE;
            shift_q <= 20'd0;
            cnt_q   <= 3'd0;
            bcd_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE, DONE_S: begin
                if (START) begin
                    shift_d = {12'd0, BIN};
                    cnt_d   = 3'd0;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                shift_d = shifted;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    bcd_d   = shifted[19:8];
                    state_d = DONE_S;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        BUSY = (state_q == CONV);
        DONE = (state_q == DONE_S);
        BCD  = bcd_q;
    end

endmodule
